// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: actuated N-phase signal controller.
// Round-robin service with demand skipping and rest in green, latched pedestrian
// calls, preemption to a selectable phase, and a fault latch that forces flashing red.
module traffic_phase_ctrl #(
   parameter int NUM_PHASES  = 4,
   parameter int TW          = 6,
   parameter int MIN_GREEN   = 3,
   parameter int MAX_GREEN   = 8,
   parameter int GAPOUT_TIME = 2,
   parameter int YELLOW_TIME = 2,
   parameter int ALLRED_TIME = 1,
   parameter int PED_TIME    = 4,
   parameter int PW          = $clog2(NUM_PHASES)  // derived, leave at default
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tick_1hz,
   input  logic                  tick_2hz,
   input  logic [NUM_PHASES-1:0] veh_sensor,
   input  logic [NUM_PHASES-1:0] ped_req,
   input  logic                  preempt_req,
   input  logic [PW-1:0]         preempt_phase,
   input  logic                  system_fault,
   output logic [NUM_PHASES-1:0] phase_green,
   output logic [NUM_PHASES-1:0] phase_yellow,
   output logic [NUM_PHASES-1:0] phase_red,
   output logic [NUM_PHASES-1:0] ped_walk,
   output logic [PW-1:0]         active_phase,
   output logic                  preempt_active,
   output logic                  fault_latched
);

   typedef enum logic [2:0] {
      ST_STARTUP, ST_GREEN, ST_YELLOW, ST_ALL_RED, ST_PRE_GREEN, ST_BLINK
   } state_t;

   state_t                  state_q, state_d;
   logic [PW-1:0]           p_q, p_d, tgt_q, tgt_d, tgt_in, rr;
   logic [TW-1:0]           timer_q, timer_d, gap_q, gap_d;
   logic [NUM_PHASES-1:0]   ped_call_q, ped_call_d, dem, p_oh, p_oh_d;
   logic                    walk_q, walk_d, pend_q, pend_d, req_q, blink_q, blink_d;
   logic                    rise, pend_eff, conflict, found, chg, gap_out, max_out;
   int                      idx;

   // Next-state decision plus next values of every timer, latch and call.
   always_comb begin
      state_d    = state_q;
      p_d        = p_q;
      rise       = preempt_req & ~req_q;
      tgt_in     = (int'(preempt_phase) >= NUM_PHASES) ? '0 : preempt_phase;
      tgt_d      = rise ? tgt_in : tgt_q;
      pend_eff   = pend_q | rise;
      dem        = veh_sensor | ped_call_q;
      p_oh       = '0;
      p_oh[p_q]  = 1'b1;
      conflict   = |(dem & ~p_oh);
      gap_out    = (timer_q >= TW'(MIN_GREEN-1)) && (gap_q >= TW'(GAPOUT_TIME)) && !walk_q;
      max_out    = (timer_q == TW'(MAX_GREEN-1));

      // Round-robin search starting after the current phase; default p+1.
      idx = int'(p_q) + 1;
      if (idx >= NUM_PHASES) idx = idx - NUM_PHASES;
      rr    = PW'(idx);
      found = 1'b0;
      for (int i = 1; i < NUM_PHASES; i++) begin
         idx = int'(p_q) + i;
         if (idx >= NUM_PHASES) idx = idx - NUM_PHASES;
         if (!found && dem[PW'(idx)]) begin
            rr    = PW'(idx);
            found = 1'b1;
         end
      end

      if (system_fault || fault_latched) begin
         state_d = ST_BLINK;
      end else begin
         unique case (state_q)
            ST_STARTUP:
               if (tick_1hz && timer_q == TW'(ALLRED_TIME-1)) begin
                  state_d = ST_GREEN;
                  p_d     = '0;
               end
            ST_GREEN:
               if (pend_eff)
                  state_d = (p_q == tgt_d) ? ST_PRE_GREEN : ST_YELLOW;
               else if (tick_1hz && conflict && (gap_out || max_out))
                  state_d = ST_YELLOW;
            ST_YELLOW:
               if (tick_1hz && timer_q == TW'(YELLOW_TIME-1)) state_d = ST_ALL_RED;
            ST_ALL_RED:
               if (tick_1hz && timer_q == TW'(ALLRED_TIME-1)) begin
                  if (pend_eff) begin
                     state_d = ST_PRE_GREEN;
                     p_d     = tgt_d;
                  end else begin
                     state_d = ST_GREEN;
                     p_d     = rr;
                  end
               end
            ST_PRE_GREEN:
               if (!preempt_req) state_d = ST_YELLOW;
            default: state_d = ST_BLINK;
         endcase
      end

      chg = (state_d != state_q);

      timer_d = chg ? '0 : (tick_1hz && timer_q != '1) ? timer_q + 1'b1 : timer_q;

      gap_d = gap_q;
      if (chg)                        gap_d = '0;
      else if (state_q == ST_GREEN) begin
         if (veh_sensor[p_q])          gap_d = '0;
         else if (tick_1hz && gap_q != '1) gap_d = gap_q + 1'b1;
      end

      // Walk only lives inside GREEN; leaving GREEN for any reason drops it.
      ped_call_d = ped_call_q | ped_req;
      walk_d     = walk_q;
      if (state_d != ST_GREEN) begin
         walk_d = 1'b0;
      end else if (chg) begin
         walk_d = ped_call_q[p_d];
         if (ped_call_q[p_d]) ped_call_d[p_d] = 1'b0;
      end else if (tick_1hz && timer_q == TW'(PED_TIME-1)) begin
         walk_d = 1'b0;
      end

      pend_d      = (chg && state_d == ST_PRE_GREEN) ? 1'b0 : pend_eff;
      blink_d     = blink_q ^ tick_2hz;
      p_oh_d      = '0;
      p_oh_d[p_d] = 1'b1;
   end

   // Controller state, timers, calls and latches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_STARTUP; p_q <= '0; tgt_q <= '0; timer_q <= '0; gap_q <= '0;
         ped_call_q <= '0; walk_q <= 1'b0; pend_q <= 1'b0; req_q <= 1'b0;
         blink_q <= 1'b0; fault_latched <= 1'b0;
      end else begin
         state_q <= state_d; p_q <= p_d; tgt_q <= tgt_d; timer_q <= timer_d; gap_q <= gap_d;
         ped_call_q <= ped_call_d; walk_q <= walk_d; pend_q <= pend_d; req_q <= preempt_req;
         blink_q <= blink_d; fault_latched <= fault_latched | system_fault;
      end
   end

   // Registered signal-head decode of the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_green <= '0; phase_yellow <= '0; phase_red <= '1; ped_walk <= '0;
         active_phase <= '0; preempt_active <= 1'b0;
      end else begin
         phase_green    <= (state_d == ST_GREEN || state_d == ST_PRE_GREEN) ? p_oh_d : '0;
         phase_yellow   <= (state_d == ST_YELLOW) ? p_oh_d : '0;
         ped_walk       <= walk_d ? p_oh_d : '0;
         active_phase   <= p_d;
         preempt_active <= (state_d == ST_PRE_GREEN);
         unique case (state_d)
            ST_GREEN, ST_PRE_GREEN, ST_YELLOW: phase_red <= ~p_oh_d;
            ST_BLINK:                          phase_red <= {NUM_PHASES{blink_d}};
            default:                           phase_red <= '1;
         endcase
      end
   end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: scoreboard bench for a 4-phase and a 3-phase controller.
// The driver steps an interval-level reference model and queues expected heads;
// a monitor compares them with the DUT outputs one cycle later.
module tb_traffic_phase_ctrl;
   localparam int AR = 1, YT = 2, MING = 3, MAXG = 8, GAPT = 2, PEDT = 4, SAT = 63;
   localparam int M_START = 0, M_GRN = 1, M_YEL = 2, M_AR = 3, M_PRE = 4, M_BLK = 5;

   typedef struct {
      logic [7:0] g, y, r, w;
      int         ap;
      bit         pa, fl;
   } exp_t;

   typedef struct {
      int n, mode, ph, el, gap, tgt;
      logic [7:0] call;
      bit walking, pend, prev, flt, blink;
      exp_t o;
   } mdl_t;

   logic       clk = 1'b0, rst_n = 1'b0, t1hz = 1'b0, t2hz = 1'b0;
   logic [7:0] veh = '0, ped = '0;
   logic       preq = 1'b0, flt = 1'b0;
   logic [1:0] pph = '0;
   logic [3:0] g4, y4, r4, w4;
   logic [2:0] g3, y3, r3, w3;
   logic [1:0] ap4, ap3;
   logic       pa4, fl4, pa3, fl3;

   exp_t q4[$], q3[$];
   mdl_t m4, m3;
   int   n_chk = 0, n_pass = 0, cyc = 0;
   bit   rnd_ticks = 0;

   always #5 clk = ~clk;

   traffic_phase_ctrl #(.NUM_PHASES(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .tick_1hz(t1hz), .tick_2hz(t2hz),
      .veh_sensor(veh[3:0]), .ped_req(ped[3:0]), .preempt_req(preq), .preempt_phase(pph),
      .system_fault(flt), .phase_green(g4), .phase_yellow(y4), .phase_red(r4),
      .ped_walk(w4), .active_phase(ap4), .preempt_active(pa4), .fault_latched(fl4));

   traffic_phase_ctrl #(.NUM_PHASES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .tick_1hz(t1hz), .tick_2hz(t2hz),
      .veh_sensor(veh[2:0]), .ped_req(ped[2:0]), .preempt_req(preq), .preempt_phase(pph),
      .system_fault(flt), .phase_green(g3), .phase_yellow(y3), .phase_red(r3),
      .ped_walk(w3), .active_phase(ap3), .preempt_active(pa3), .fault_latched(fl3));

   // Signal heads implied by a mode, phase and walk flag.
   function automatic exp_t heads(mdl_t m);
      exp_t o;
      logic [7:0] mask, one;
      mask = 8'((1 << m.n) - 1);
      one  = 8'(1 << m.ph);
      o.g = '0; o.y = '0; o.w = '0; o.r = mask;
      if (m.mode == M_GRN || m.mode == M_PRE) begin o.g = one; o.r = mask & ~one; end
      if (m.mode == M_YEL)                    begin o.y = one; o.r = mask & ~one; end
      if (m.mode == M_BLK) o.r = m.blink ? mask : 8'h00;
      if (m.walking) o.w = one;
      o.ap = m.ph;
      o.pa = (m.mode == M_PRE);
      o.fl = m.flt;
      return o;
   endfunction

   function automatic mdl_t mreset(int n);
      mdl_t m;
      m.n = n; m.mode = M_START; m.ph = 0; m.el = 0; m.gap = 0; m.tgt = 0;
      m.call = '0; m.walking = 0; m.pend = 0; m.prev = 0; m.flt = 0; m.blink = 0;
      m.o = heads(m);
      return m;
   endfunction

   // Next phase to serve: first demanding phase after ph, else simply the next one.
   function automatic int pick(int ph, int n, logic [7:0] dem);
      for (int i = 1; i < n; i++)
         if (dem[(ph + i) % n]) return (ph + i) % n;
      return (ph + 1) % n;
   endfunction

   // One clock of the reference controller; elapsed seconds counted as completed ticks.
   function automatic mdl_t step(mdl_t m, logic [7:0] veh_i, logic [7:0] ped_i,
                                 bit rq, int pp, bit f, bit t1, bit t2);
      mdl_t s;
      logic [7:0] mask, vv, dem;
      bit rise, pend, other, changed, enter_g;
      int tgt, nm, np, done;
      s    = m;
      mask = 8'((1 << m.n) - 1);
      vv   = veh_i & mask;
      rise = rq && !m.prev;
      pend = m.pend || rise;
      tgt  = rise ? ((pp >= m.n) ? 0 : pp) : m.tgt;
      dem  = vv | m.call;
      other = (dem & ~8'(1 << m.ph)) != 0;
      done = m.el + 1;  // seconds completed if this cycle carries a tick
      nm = m.mode; np = m.ph;
      if (f || m.flt) nm = M_BLK;
      else case (m.mode)
         M_START: if (t1 && done == AR) begin nm = M_GRN; np = 0; end
         M_GRN: begin
            if (pend) nm = (m.ph == tgt) ? M_PRE : M_YEL;
            else if (t1 && other &&
                     ((done >= MING && m.gap >= GAPT && !m.walking) || done == MAXG))
               nm = M_YEL;
         end
         M_YEL: if (t1 && done == YT) nm = M_AR;
         M_AR: if (t1 && done == AR) begin
            if (pend) begin nm = M_PRE; np = tgt; end
            else begin nm = M_GRN; np = pick(m.ph, m.n, dem); end
         end
         M_PRE: if (!rq) nm = M_YEL;
         default: nm = M_BLK;
      endcase
      changed = (nm != m.mode);
      enter_g = changed && nm == M_GRN;
      s.call  = m.call | (ped_i & mask);
      if (nm != M_GRN)           s.walking = 0;
      else if (enter_g)          s.walking = m.call[np];
      else if (t1 && done == PEDT) s.walking = 0;
      if (enter_g && m.call[np]) s.call[np] = 1'b0;
      if (changed) s.el = 0;
      else if (t1) s.el = (m.el < SAT) ? m.el + 1 : SAT;
      if (changed) s.gap = 0;
      else if (m.mode == M_GRN) begin
         if (vv[m.ph]) s.gap = 0;
         else if (t1) s.gap = (m.gap < SAT) ? m.gap + 1 : SAT;
      end
      s.pend  = (changed && nm == M_PRE) ? 1'b0 : pend;
      s.tgt   = tgt;
      s.prev  = rq;
      s.flt   = m.flt || f;
      s.blink = m.blink ^ t2;
      s.mode  = nm;
      s.ph    = np;
      s.o     = heads(s);
      return s;
   endfunction

   // Drive one cycle of inputs and queue the heads the DUTs must show after the next edge.
   task automatic cycle(input logic [7:0] v, input logic [7:0] pr, input bit rq,
                        input logic [1:0] pp, input bit f, input bit rn);
      bit a, b;
      @(negedge clk);
      if (rnd_ticks) begin
         a = ($urandom_range(3) == 0);
         b = ($urandom_range(2) == 0);
      end else begin
         a = (cyc % 4 == 3);
         b = (cyc % 2 == 1);
      end
      cyc++;
      veh = v; ped = pr; preq = rq; pph = pp; flt = f; t1hz = a; t2hz = b; rst_n = rn;
      if (!rn) begin
         m4 = mreset(4);
         m3 = mreset(3);
      end else begin
         m4 = step(m4, v, pr, rq, int'(pp), f, a, b);
         m3 = step(m3, v, pr, rq, int'(pp), f, a, b);
      end
      q4.push_back(m4.o);
      q3.push_back(m3.o);
   endtask

   task automatic check(input string nm, input exp_t a, input exp_t e);
      n_chk++;
      if (a.g === e.g && a.y === e.y && a.r === e.r && a.w === e.w &&
          a.ap == e.ap && a.pa === e.pa && a.fl === e.fl)
         n_pass++;
      else
         $display("FAIL %s t=%0t got g=%b y=%b r=%b w=%b ap=%0d pa=%b fl=%b want g=%b y=%b r=%b w=%b ap=%0d pa=%b fl=%b",
                  nm, $time, a.g, a.y, a.r, a.w, a.ap, a.pa, a.fl,
                  e.g, e.y, e.r, e.w, e.ap, e.pa, e.fl);
   endtask

   // Monitor: compare each presented output against the oldest queued expectation.
   initial begin
      exp_t a, e;
      forever begin
         @(posedge clk);
         #1;
         if (q4.size() > 0) begin
            e = q4.pop_front();
            a.g = {4'b0, g4}; a.y = {4'b0, y4}; a.r = {4'b0, r4}; a.w = {4'b0, w4};
            a.ap = int'(ap4); a.pa = pa4; a.fl = fl4;
            check("n4", a, e);
         end
         if (q3.size() > 0) begin
            e = q3.pop_front();
            a.g = {5'b0, g3}; a.y = {5'b0, y3}; a.r = {5'b0, r3}; a.w = {5'b0, w3};
            a.ap = int'(ap3); a.pa = pa3; a.fl = fl3;
            check("n3", a, e);
         end
      end
   end

   initial begin
      logic [7:0] vr, pr;
      bit rq, fr, rr;
      logic [1:0] pp;
      m4 = mreset(4);
      m3 = mreset(3);
      // Reset, then rest in phase 0 green with no demand.
      repeat (3) cycle(8'h00, 8'h00, 0, 2'd0, 0, 0);
      repeat (80) cycle(8'h00, 8'h00, 0, 2'd0, 0, 1);
      // Max-out with phases 0 and 2 demanding.
      repeat (150) cycle(8'h05, 8'h00, 0, 2'd0, 0, 1);
      // Gap-out into a pedestrian call on phase 1.
      repeat (2) cycle(8'h00, 8'h00, 0, 2'd0, 0, 0);
      repeat (6) cycle(8'h00, 8'h00, 0, 2'd0, 0, 1);
      cycle(8'h00, 8'h02, 0, 2'd0, 0, 1);
      repeat (120) cycle(8'h00, 8'h00, 0, 2'd0, 0, 1);
      // Preemption to phase 3 (maps to phase 0 on the 3-phase unit), then release.
      repeat (2) cycle(8'h00, 8'h00, 0, 2'd0, 0, 0);
      repeat (9) cycle(8'h00, 8'h00, 0, 2'd3, 0, 1);
      repeat (80) cycle(8'h01, 8'h00, 1, 2'd3, 0, 1);
      repeat (60) cycle(8'h00, 8'h00, 0, 2'd3, 0, 1);
      // Fault while cycling, blink persists after the fault clears, then reset.
      repeat (40) cycle(8'h05, 8'h00, 0, 2'd0, 0, 1);
      cycle(8'h05, 8'h00, 0, 2'd0, 1, 1);
      repeat (40) cycle(8'h05, 8'h00, 0, 2'd0, 0, 1);
      repeat (2) cycle(8'h00, 8'h00, 0, 2'd0, 0, 0);
      // Fault in the same cycle as a preemption request.
      repeat (10) cycle(8'h00, 8'h00, 0, 2'd2, 0, 1);
      cycle(8'h00, 8'h00, 1, 2'd2, 1, 1);
      repeat (20) cycle(8'h00, 8'h00, 1, 2'd2, 0, 1);
      repeat (2) cycle(8'h00, 8'h00, 0, 2'd0, 0, 0);
      // Randomised traffic, pedestrians, preemption, rare faults and resets.
      rnd_ticks = 1;
      vr = '0; rq = 0; pp = '0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(7) == 0) vr[$urandom_range(3)] = ~vr[$urandom_range(3)];
         pr = ($urandom_range(24) == 0) ? 8'(1 << $urandom_range(3)) : 8'h00;
         if ($urandom_range(80) == 0) rq = !rq;
         if ($urandom_range(40) == 0) pp = 2'($urandom_range(3));
         fr = ($urandom_range(1999) == 0);
         rr = ($urandom_range(499) != 0);
         cycle(vr, pr, rq, pp, fr, rr);
      end
      @(posedge clk);
      #3;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised, actuated N-phase signal controller that replaces the fixed two-direction NS/EW sequencer in the intersection top level. It serves up to eight conflicting phases in round-robin order, skips phases with no demand, and rests in green when nothing else is waiting. It adds latched pedestrian calls per phase and preemption to a selectable phase. A system fault latches the block into flashing red until reset. It consumes the shared `tick_1hz`/`tick_2hz` strobes from the tick generator.

## Interface
- `NUM_PHASES`, 4: number of phases, 2..8; `PW = $clog2(NUM_PHASES)`.
- `TW`, 6: width of the seconds timer and the gap counter.
- `MIN_GREEN`, 3: minimum green in seconds, ≥1.
- `MAX_GREEN`, 8: maximum green in seconds while conflicting demand exists, > `MIN_GREEN`.
- `GAPOUT_TIME`, 2: consecutive seconds without a vehicle that end green early.
- `YELLOW_TIME`, 2; `ALLRED_TIME`, 1; `PED_TIME`, 4: interval lengths in seconds, each ≥1.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick_1hz`, `tick_2hz` in 1: one-cycle strobes.
- `veh_sensor` in NUM_PHASES: vehicle presence, one bit per phase.
- `ped_req` in NUM_PHASES: pedestrian button pulses, one bit per phase.
- `preempt_req` in 1: level request for preemption.
- `preempt_phase` in PW: target phase; values ≥ NUM_PHASES map to phase 0.
- `system_fault` in 1: fault input.
- `phase_green`, `phase_yellow`, `phase_red` out NUM_PHASES: signal heads, one bit per phase.
- `ped_walk` out NUM_PHASES: walk indication per phase.
- `active_phase` out PW: phase currently served.
- `preempt_active` out 1: high in PRE_GREEN.
- `fault_latched` out 1: fault latch state.

## Operation
- States: STARTUP, GREEN, YELLOW, ALL_RED, PRE_GREEN, BLINK. Reset state is STARTUP.
- Reset values: `phase_red` all ones; `phase_green`, `phase_yellow` and `ped_walk` all zero; `active_phase` 0; `preempt_active` 0; `fault_latched` 0; ped calls, timer, gap counter and blink toggle all 0.
- Timer:
  - Cleared on every state change.
  - Increments on `tick_1hz`, saturating at all-ones.
  - A timed interval of D seconds ends on the `tick_1hz` cycle where timer == D-1, so the interval lasts exactly D ticks.
- STARTUP: all red for ALLRED_TIME, then GREEN with p = 0.
- Demand: `dem[q] = veh_sensor[q] | ped_call[q]`. Conflicting demand exists when any `dem[q]` is set for q ≠ p.
- Ped calls:
  - `ped_call[q]` is set by `ped_req[q]`.
  - The call is cleared in the cycle its walk starts. A `ped_req` in that same cycle is absorbed.
  - Calls survive preemption.
- Walk:
  - Starts on GREEN entry if `ped_call[p]` is set.
  - `ped_walk[p]` stays high for PED_TIME seconds.
  - It is dropped immediately on preemption or fault.
- Gap counter:
  - In GREEN, increments on `tick_1hz` while `veh_sensor[p]` is 0.
  - Clears in any cycle `veh_sensor[p]` is 1, and on state change.
  - Saturates at all-ones.
- GREEN exit to YELLOW requires a `tick_1hz` cycle with conflicting demand, plus one of:
  - gap-out: timer ≥ MIN_GREEN-1, gap ≥ GAPOUT_TIME, and walk inactive; or
  - max-out: timer == MAX_GREEN-1. Max-out truncates an active walk.
- Rest in green: with no conflicting demand, GREEN holds indefinitely.
- YELLOW: lasts YELLOW_TIME, then ALL_RED.
- ALL_RED: lasts ALLRED_TIME. On exit, next p is chosen as follows:
  - if preemption is pending, p is the latched target and the next state is PRE_GREEN;
  - otherwise p is the first q in p+1, p+2, … (mod N) with `dem[q]`; if none, p+1 mod N.
- Preemption:
  - The target is latched on the rising edge of `preempt_req`, which also sets `pending`.
  - In GREEN of a non-target phase, go to YELLOW in the next cycle, ignoring MIN_GREEN.
  - In GREEN of the target phase, go directly to PRE_GREEN.
  - YELLOW and ALL_RED always complete their full timing.
  - PRE_GREEN: target green, no walk. Held while `preempt_req` is high. On release, go to YELLOW; `pending` clears on PRE_GREEN entry.
- Fault:
  - `system_fault` high in any cycle sets `fault_latched`. Only `rst_n` clears it.
  - Next cycle the state is BLINK.
  - In BLINK, all greens, yellows and walks are 0 and every `phase_red` equals the blink toggle.
  - The blink toggle is free-running and flips on `tick_2hz`.
- Priority: fault > preemption > normal sequencing.

## Timing
- Outputs are registered decodes of the state, one cycle after the transition decision.
- Exactly one phase may show green or yellow at any time. A yellow is always followed by ≥ ALLRED_TIME of all red before any green.
- A fault in the same cycle as `preempt_req` goes to BLINK, and `preempt_active` stays 0.
- An asynchronous reset mid-interval returns to the reset values immediately. Outputs restart from STARTUP after `rst_n` rises.

## Test plan
Defaults for all scenarios: N=4, MIN=3, MAX=8, GAP=2, Y=2, AR=1, PED=4.
- Reset, no demand: after 1 tick of all red, phase 0 is green and rests indefinitely. `active_phase`=0, `phase_red`=4'b1110.
- Max-out: `veh_sensor`=4'b0101 held. Phase 0 is green for 8 ticks, yellow 2, all-red 1, then phase 2 green (phase 1 is skipped).
- Gap-out with ped call: `ped_req[1]` pulse, `veh_sensor[0]`=0. Phase 0 green lasts 3 ticks, then Y/AR. Phase 1 green with `ped_walk[1]`=1 for 4 ticks; `ped_call[1]` clears on walk start.
- Preemption: during phase 0 green at tick 1, preempt_req=1 with `preempt_phase`=3. Yellow follows the next cycle, then 2 ticks yellow, 1 all-red, then phase 3 green with `preempt_active`=1. On release: yellow, then normal operation.
- Fault: `system_fault` pulse during YELLOW. The next cycle is BLINK and `phase_red` toggles all ones/zeros on each `tick_2hz`. The state persists after the fault clears, and `rst_n`=0 restores reset values.
- Out-of-range preempt: N=3, `preempt_phase`=3. Phase 0 is served as the preempt phase.
